// File: rtl/ifetch_queue.sv
// Instruction fetch unit: drives a 1-cycle-latency ROM and buffers words in a DEPTH-entry queue for decode.
// Optional misaligned-redirect fault detection is enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch_queue #(
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    imem_en,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic [31:0]             imem_rdata,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [31:0]             inst,
    output logic [31:0]             inst_pc,
    output logic [31:0]             inst_pc_plus4,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    fetch_fault
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    logic [31:0]    fetch_pc_r;
    logic [31:0]    tag_pc_r;
    logic           inflight_r;
    logic [CW-1:0]  count_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [31:0]    q_inst_r [DEPTH];
    logic [31:0]    q_pc_r   [DEPTH];
    logic [31:0]    q_pc4_r  [DEPTH];

    logic           fault_s;
    logic           issue_s;
    logic           push_s;
    logic           pop_s;
    logic [CW:0]    pending_s;
    logic [31:0]    redir_target_s;

    // Low two bits are never fetched from; an aligned copy is what the PC loads.
    assign redir_target_s = redirect_pc & 32'hFFFF_FFFC;

    // Issue credit: queued words plus the outstanding read must leave room for one more.
    always_comb begin
        pending_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
        issue_s   = 1'b0;
        if (!rst && !hold && !redirect_valid && !fault_s && (pending_s < DEPTH_V)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        push_s = inflight_r && !redirect_valid;
        pop_s  = (count_r != {CW{1'b0}}) && inst_ready;
    end

    // Fetch PC and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            tag_pc_r   <= 32'h0000_0000;
            inflight_r <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_r <= redir_target_s;
            tag_pc_r   <= tag_pc_r;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                tag_pc_r   <= fetch_pc_r;
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end else begin
                tag_pc_r   <= tag_pc_r;
                fetch_pc_r <= fetch_pc_r;
            end
        end
    end

    // Instruction queue storage, pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= {CW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_inst_r[i] <= 32'h0000_0000;
                q_pc_r[i]   <= 32'h0000_0000;
                q_pc4_r[i]  <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            count_r  <= {CW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                q_inst_r[wr_ptr_r] <= imem_rdata;
                q_pc_r[wr_ptr_r]   <= tag_pc_r;
                q_pc4_r[wr_ptr_r]  <= tag_pc_r + 32'd4;
                wr_ptr_r           <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_r;

    // Sticky misalignment fault; only a later aligned redirect or reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (redirect_valid) begin
            fault_r <= (redirect_pc[1:0] != 2'b00);
        end else begin
            fault_r <= fault_r;
        end
    end
    assign fault_s = fault_r;
`else
    assign fault_s = 1'b0;
`endif

    assign imem_en       = issue_s;
    assign imem_addr     = fetch_pc_r[ADDR_W+1:2];
    assign inst_valid    = (count_r != {CW{1'b0}});
    assign inst          = q_inst_r[rd_ptr_r];
    assign inst_pc       = q_pc_r[rd_ptr_r];
    assign inst_pc_plus4 = q_pc4_r[rd_ptr_r];
    assign q_count       = count_r;
    assign fetch_fault   = fault_s;
endmodule
